mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Final MEM/WB pipeline register of the 5-stage core; sits directly upstream of the register file write port.
- Captures the memory-stage result, formats load data (byte/half extract, sign/zero extend), selects the write-back source, and presents a registered write port.
- Also drives the forwarding bus to the hazard unit and keeps a retired-instruction counter.

Parameters:
- DATA_WIDTH, 32 (`ISA_WIDTH), datapath width.
- ADDR_WIDTH, 5 (`REG_FILE_ADDR_WIDTH), register address width.
- CNT_WIDTH, 32, retired-instruction counter width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hold stage contents.
- flush  in  1  insert bubble.
- in_valid  in  1  MEM-stage instruction valid.
- in_reg_write  in  1  instruction writes a GPR.
- in_rd  in  ADDR_WIDTH  destination register.
- in_wb_sel  in  2  write-back source: ALU / MEM / LINK.
- in_load_type  in  3  LW, LH, LHU, LB, LBU.
- in_alu_result  in  DATA_WIDTH  ALU result; bits [1:0] are the load byte offset.
- in_mem_rdata  in  DATA_WIDTH  raw word from data memory.
- in_link_addr  in  DATA_WIDTH  PC+8 for JAL/JALR.
- write_en  out  1  to register file.
- write_reg_addr  out  ADDR_WIDTH  to register file.
- write_data  out  DATA_WIDTH  to register file.
- fwd_valid  out  1  forwarding bus valid (equals write_en).
- fwd_rd  out  ADDR_WIDTH  forwarding register address.
- fwd_data  out  DATA_WIDTH  forwarding data.
- exc_misaligned  out  1  one-cycle pulse for a misaligned load.
- retired_count  out  CNT_WIDTH  retired-instruction counter.

Behaviour:
- All outputs are registered. Latency is 1 cycle from input to write port.
- Reset (rst=1 at posedge): valid=0. All outputs are 0, including write_en, exc_misaligned and retired_count.
- Update priority at posedge: rst > flush > stall > capture.
  - flush: valid<=0, write_en<=0, exc_misaligned<=0. Data outputs are don't-care; drive them to 0.
  - stall (no flush): all registers hold. exc_misaligned is forced to 0 so the pulse never repeats.
  - capture: register the formatted result of the current inputs.
- Load formatting (little-endian, off=in_alu_result[1:0]):
  - LW: word as-is.
  - LH/LHU: half = off[1] ? [31:16] : [15:0], then sign-/zero-extend.
  - LB/LBU: byte at bits [8*off+7 : 8*off], then sign-/zero-extend.
- Misaligned load (wb_sel=MEM and valid):
  - Defined as LW with off!=0, or LH/LHU with off[0]=1.
  - Sets exc_misaligned=1 for that capture and suppresses write_en. retired_count does not increment.
- Write-back mux: ALU -> in_alu_result; MEM -> formatted load; LINK -> in_link_addr. The encoding 2'b11 is treated as ALU.
- write_en = in_valid & in_reg_write & (in_rd != 0) & ~misaligned. Writes to r0 are never issued.
- The fwd_* outputs mirror the write_* outputs exactly, in the same cycle.
- retired_count:
  - Increments by 1 on each capture with in_valid=1 and no misalignment.
  - Increments regardless of reg_write (stores and branches count).
  - Wraps modulo 2^CNT_WIDTH. Holds on stall, flush and the misalignment case.
- Simultaneous stall+flush: flush wins and the counter holds.
- Reset asserted mid-stall: reset wins on the next posedge.

Decomposition:
- Add to definitions.v:
  - `WB_SEL_ALU=2'd0, `WB_SEL_MEM=2'd1, `WB_SEL_LINK=2'd2.
  - `LOAD_LW=3'd0, `LOAD_LH=3'd1, `LOAD_LHU=3'd2, `LOAD_LB=3'd3, `LOAD_LBU=3'd4.
- One combinational sub-module, load_formatter. Inputs: raw word, offset, load_type. Outputs: formatted data and misaligned flag.

Test Plan:
- Reset: hold rst=1 for 2 cycles with valid inputs -> all outputs 0. After release, capture wb_sel=ALU, rd=5, alu=0x1234 -> next cycle write_en=1, addr=5, data=0x1234, retired_count=1.
- Loads with mem_rdata=0x8081F2F3:
  - LB off=1 -> 0xFFFFFFF2.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF8081.
  - LHU off=0 -> 0x0000F2F3.
- Misaligned LW (alu=0x1002) with rd=7 -> exc_misaligned=1 for exactly one cycle, write_en=0, counter unchanged.
- rd=0 with reg_write=1 -> write_en=0 and counter increments. JAL with wb_sel=LINK, link=0x00400008, rd=31 -> data=0x00400008.
- Stall 3 cycles after a capture -> outputs and counter frozen, exc_misaligned stays 0. stall+flush together -> write_en=0, counter held.
- Preload counter to 0xFFFFFFFF (by 2^32-1 retirements, or by forcing the counter in the bench), then retire one more -> retired_count=0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB stage: write-back source select and load width/sign.
package mem_wb_stage_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_LINK = 2'd2,
    WB_SEL_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    LOAD_LW  = 3'd0,
    LOAD_LH  = 3'd1,
    LOAD_LHU = 3'd2,
    LOAD_LB  = 3'd3,
    LOAD_LBU = 3'd4
  } load_type_e;

endpackage

// File: rtl/mem_wb_stage_load_formatter.sv
// Little-endian load extraction with sign/zero extension and alignment check.
module load_formatter
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_raw,
  input  logic [1:0]            i_off,
  input  logic [2:0]            i_load_type,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_raw[{i_off, 3'b000} +: 8];
  assign w_half = i_raw[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_data       = i_raw;
    o_misaligned = 1'b0;
    case (load_type_e'(i_load_type))
      LOAD_LW:  o_misaligned = (i_off != 2'b00);
      LOAD_LH: begin
        o_data       = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
        o_misaligned = i_off[0];
      end
      LOAD_LHU: begin
        o_data       = {{(DATA_WIDTH-16){1'b0}}, w_half};
        o_misaligned = i_off[0];
      end
      LOAD_LB:  o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      LOAD_LBU: o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      default:  ;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats loads, selects write-back data, drives the
// register-file write port and forwarding bus, and counts retired instructions.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_reg_write,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [1:0]            in_wb_sel,
  input  logic [2:0]            in_load_type,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_mem_rdata,
  input  logic [DATA_WIDTH-1:0] in_link_addr,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_reg_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  exc_misaligned,
  output logic [CNT_WIDTH-1:0]  retired_count
);

  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_fmt_misaligned;
  logic                  w_misaligned;
  logic                  w_write_en;
  logic [DATA_WIDTH-1:0] w_wb_data;

  logic                  r_write_en;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_exc;
  logic [CNT_WIDTH-1:0]  r_retired_count;

  load_formatter #(.DATA_WIDTH(DATA_WIDTH)) u_fmt (
    .i_raw        (in_mem_rdata),
    .i_off        (in_alu_result[1:0]),
    .i_load_type  (in_load_type),
    .o_data       (w_load_data),
    .o_misaligned (w_fmt_misaligned)
  );

  // Alignment only matters when the loaded word is actually written back.
  assign w_misaligned = in_valid && (wb_sel_e'(in_wb_sel) == WB_SEL_MEM) && w_fmt_misaligned;
  assign w_write_en   = in_valid && in_reg_write && (in_rd != '0) && !w_misaligned;

  always_comb begin
    w_wb_data = in_alu_result;
    case (wb_sel_e'(in_wb_sel))
      WB_SEL_MEM:  w_wb_data = w_load_data;
      WB_SEL_LINK: w_wb_data = in_link_addr;
      default:     w_wb_data = in_alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write_en      <= 1'b0;
      r_rd            <= '0;
      r_data          <= '0;
      r_exc           <= 1'b0;
      r_retired_count <= '0;
    end else if (flush) begin
      r_write_en <= 1'b0;
      r_rd       <= '0;
      r_data     <= '0;
      r_exc      <= 1'b0;
    end else if (stall) begin
      // Hold everything except the exception, so a pulse is never repeated.
      r_exc <= 1'b0;
    end else begin
      r_write_en <= w_write_en;
      r_rd       <= in_rd;
      r_data     <= w_wb_data;
      r_exc      <= w_misaligned;
      if (in_valid && !w_misaligned) r_retired_count <= r_retired_count + 1'b1;
    end
  end

  assign write_en       = r_write_en;
  assign write_reg_addr = r_rd;
  assign write_data     = r_data;
  assign fwd_valid      = r_write_en;
  assign fwd_rd         = r_rd;
  assign fwd_data       = r_data;
  assign exc_misaligned = r_exc;
  assign retired_count  = r_retired_count;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table plus stall/flush/reset/wrap sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        in_valid, in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_load_type;
  logic [31:0] in_alu_result, in_mem_rdata, in_link_addr;
  logic        write_en, fwd_valid, exc_misaligned;
  logic [4:0]  write_reg_addr, fwd_rd;
  logic [31:0] write_data, fwd_data, retired_count;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_wb_sel(in_wb_sel), .in_load_type(in_load_type),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_link_addr(in_link_addr),
    .write_en(write_en), .write_reg_addr(write_reg_addr), .write_data(write_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .exc_misaligned(exc_misaligned), .retired_count(retired_count)
  );

  typedef struct {
    logic        valid;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  wbs;
    logic [2:0]  lt;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] link;
    logic        e_we;
    logic [31:0] e_data;
    logic        chk_data;
    logic        e_exc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_outs(input string tag, input logic e_we, input logic [4:0] e_rd,
                          input logic [31:0] e_data, input logic chk_data,
                          input logic e_exc, input logic [31:0] e_cnt);
    chk({tag, "_we"},  {31'd0, write_en}, {31'd0, e_we});
    chk({tag, "_rd"},  {27'd0, write_reg_addr}, {27'd0, e_rd});
    if (chk_data) chk({tag, "_data"}, write_data, e_data);
    chk({tag, "_fwd_valid"}, {31'd0, fwd_valid}, {31'd0, e_we});
    chk({tag, "_fwd_rd"}, {27'd0, fwd_rd}, {27'd0, e_rd});
    if (chk_data) chk({tag, "_fwd_data"}, fwd_data, e_data);
    chk({tag, "_exc"}, {31'd0, exc_misaligned}, {31'd0, e_exc});
    chk({tag, "_cnt"}, retired_count, e_cnt);
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] wbs, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] link);
    in_valid = v; in_reg_write = rw; in_rd = rd; in_wb_sel = wbs;
    in_load_type = lt; in_alu_result = alu; in_mem_rdata = mem; in_link_addr = link;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] M = 32'h8081F2F3;

  initial begin
    //          v     rw    rd     wbs   lt    alu           mem link          we    data          cd    exc   cnt
    vecs[0]  = '{1'b1, 1'b1, 5'd5,  2'd0, 3'd0, 32'h00001234, M, 32'h0,        1'b1, 32'h00001234, 1'b1, 1'b0, 32'd1};
    vecs[1]  = '{1'b1, 1'b1, 5'd3,  2'd1, 3'd3, 32'h00001001, M, 32'h0,        1'b1, 32'hFFFFFFF2, 1'b1, 1'b0, 32'd2};
    vecs[2]  = '{1'b1, 1'b1, 5'd4,  2'd1, 3'd4, 32'h00001003, M, 32'h0,        1'b1, 32'h00000080, 1'b1, 1'b0, 32'd3};
    vecs[3]  = '{1'b1, 1'b1, 5'd6,  2'd1, 3'd1, 32'h00001002, M, 32'h0,        1'b1, 32'hFFFF8081, 1'b1, 1'b0, 32'd4};
    vecs[4]  = '{1'b1, 1'b1, 5'd8,  2'd1, 3'd2, 32'h00001000, M, 32'h0,        1'b1, 32'h0000F2F3, 1'b1, 1'b0, 32'd5};
    vecs[5]  = '{1'b1, 1'b1, 5'd7,  2'd1, 3'd0, 32'h00001002, M, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'd5};
    vecs[6]  = '{1'b1, 1'b1, 5'd0,  2'd0, 3'd0, 32'h00000055, M, 32'h0,        1'b0, 32'h00000055, 1'b1, 1'b0, 32'd6};
    vecs[7]  = '{1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 32'h00001002, M, 32'h00400008, 1'b1, 32'h00400008, 1'b1, 1'b0, 32'd7};
    vecs[8]  = '{1'b1, 1'b1, 5'd9,  2'd3, 3'd0, 32'hDEADBEEF, M, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'd8};
    vecs[9]  = '{1'b1, 1'b0, 5'd2,  2'd0, 3'd0, 32'h00000040, M, 32'h0,        1'b0, 32'h00000040, 1'b1, 1'b0, 32'd9};
    vecs[10] = '{1'b0, 1'b1, 5'd10, 2'd0, 3'd0, 32'h00000077, M, 32'h0,        1'b0, 32'h00000077, 1'b1, 1'b0, 32'd9};
    vecs[11] = '{1'b1, 1'b1, 5'd11, 2'd1, 3'd0, 32'h00001000, M, 32'h0,        1'b1, 32'h8081F2F3, 1'b1, 1'b0, 32'd10};
    vecs[12] = '{1'b1, 1'b1, 5'd12, 2'd1, 3'd3, 32'h00001002, M, 32'h0,        1'b1, 32'hFFFFFF81, 1'b1, 1'b0, 32'd11};
    vecs[13] = '{1'b1, 1'b1, 5'd12, 2'd1, 3'd2, 32'h00001003, M, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'd11};
    vecs[14] = '{1'b1, 1'b1, 5'd13, 2'd0, 3'd0, 32'h00001002, M, 32'h0,        1'b1, 32'h00001002, 1'b1, 1'b0, 32'd12};
    vecs[15] = '{1'b0, 1'b1, 5'd14, 2'd1, 3'd0, 32'h00001001, M, 32'h0,        1'b0, 32'h8081F2F3, 1'b1, 1'b0, 32'd12};

    // Reset held for two cycles with a live instruction on the inputs
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h00001234, M, 32'h0);
    tick(); tick();
    chk_outs("reset", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].rw, vecs[i].rd, vecs[i].wbs, vecs[i].lt,
            vecs[i].alu, vecs[i].mem, vecs[i].link);
      tick();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].rd, vecs[i].e_data,
               vecs[i].chk_data, vecs[i].e_exc, vecs[i].e_cnt);
    end

    // Capture then stall three cycles with different inputs applied
    drive(1'b1, 1'b1, 5'd14, 2'd0, 3'd0, 32'h0000A5A5, M, 32'h0);
    tick();
    chk_outs("pre_stall", 1'b1, 5'd14, 32'h0000A5A5, 1'b1, 1'b0, 32'd13);
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd20, 2'd1, 3'd0, 32'h00001001, M, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_outs($sformatf("stall%0d", i), 1'b1, 5'd14, 32'h0000A5A5, 1'b1, 1'b0, 32'd13);
    end

    // Misaligned pulse followed by a stall: pulse must not repeat
    stall = 1'b0;
    drive(1'b1, 1'b1, 5'd7, 2'd1, 3'd0, 32'h00001002, M, 32'h0);
    tick();
    chk_outs("misal", 1'b0, 5'd7, 32'h0, 1'b0, 1'b1, 32'd13);
    stall = 1'b1;
    tick();
    chk_outs("misal_stall", 1'b0, 5'd7, 32'h0, 1'b0, 1'b0, 32'd13);

    // Stall and flush together: flush wins, counter holds
    flush = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h00000099, M, 32'h0);
    tick();
    chk_outs("stall_flush", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'd13);
    flush = 1'b0; stall = 1'b0;

    // Reset asserted while stalled
    drive(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 32'h00000009, M, 32'h0);
    tick();
    chk_outs("pre_rst_stall", 1'b1, 5'd3, 32'h00000009, 1'b1, 1'b0, 32'd14);
    stall = 1'b1; rst = 1'b1;
    tick();
    chk_outs("rst_stall", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'd0);
    stall = 1'b0; rst = 1'b0;

    // Counter wrap from all-ones
    force dut.r_retired_count = 32'hFFFFFFFF;
    #1;
    release dut.r_retired_count;
    chk("wrap_preload", retired_count, 32'hFFFFFFFF);
    drive(1'b1, 1'b1, 5'd1, 2'd0, 3'd0, 32'h00000001, M, 32'h0);
    tick();
    chk_outs("wrap", 1'b1, 5'd1, 32'h00000001, 1'b1, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
